// File: rtl/rpc2_ctrl_fifo_reader_pkg.sv
// Shared constants for the RPC2 controller FIFO reader: FSM state encoding
// and output buffer sizing.
package rpc2_ctrl_fifo_reader_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/rpc2_ctrl_skid_buf.sv
// Two-entry register buffer between the FIFO pop side and the master stream.
// Outputs come only from the head register, never from the push path.
module rpc2_ctrl_skid_buf
  import rpc2_ctrl_fifo_reader_pkg::*;
#(
  parameter int W = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic [W-1:0]         i_push_entry,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [W-1:0]         o_entry,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [W-1:0]         r_head;
  logic [W-1:0]         r_tail;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_pop;

  assign w_pop   = (r_count != '0) && i_ready;
  assign o_valid = (r_count != '0);
  assign o_entry = r_head;
  assign o_count = r_count;

  // The caller never pushes into a full buffer, so push+pop implies count 1 or 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == '0) r_head <= i_push_entry;
          else               r_tail <= i_push_entry;
          r_count <= r_count + CNT_WIDTH'(1);
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - CNT_WIDTH'(1);
        end
        2'b11: begin
          if (r_count == CNT_WIDTH'(1)) begin
            r_head <= i_push_entry;
          end else begin
            r_head <= r_tail;
            r_tail <= i_push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rpc2_ctrl_fifo_reader.sv
// Burst reader: pops len+1 words from a CDC FIFO read port and replays them
// on a valid/ready master stream, tagging the final beat with m_last.
module rpc2_ctrl_fifo_reader
  import rpc2_ctrl_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_rd_ready,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            dbg_state
);

  // Stream handshake: a beat transfers on a rising edge where m_valid and
  // m_ready are both high; m_data/m_last stay stable while m_valid waits.

  logic [1:0]           r_state;
  logic [LEN_WIDTH:0]   r_beats_left;
  logic                 r_done;
  logic [CNT_WIDTH-1:0] w_buf_count;
  logic [DATA_WIDTH:0]  w_head;
  logic                 w_abort;
  logic                 w_final_pop;
  logic                 w_last_hs;

  assign w_abort     = abort && (r_state != IDLE);
  assign fifo_rd_en  = (r_state == RUN) && fifo_rd_ready && (r_beats_left != '0)
                       && (w_buf_count < CNT_WIDTH'(BUF_DEPTH)) && !abort;
  assign w_final_pop = fifo_rd_en && (r_beats_left == (LEN_WIDTH+1)'(1));
  assign w_last_hs   = m_valid && m_ready && m_last;

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign m_data    = w_head[DATA_WIDTH-1:0];
  assign m_last    = w_head[DATA_WIDTH];
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beats_left <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state      <= IDLE;
        r_beats_left <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state      <= RUN;
              r_beats_left <= {1'b0, len} + (LEN_WIDTH+1)'(1);
            end
          end
          RUN: begin
            if (fifo_rd_en) r_beats_left <= r_beats_left - (LEN_WIDTH+1)'(1);
            if (w_final_pop) r_state <= FLUSH;
          end
          FLUSH: begin
            if (w_last_hs) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  rpc2_ctrl_skid_buf #(
    .W(DATA_WIDTH + 1)
  ) u_skid_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_abort),
    .i_push       (fifo_rd_en),
    .i_push_entry ({w_final_pop, fifo_rd_data}),
    .i_ready      (m_ready),
    .o_valid      (m_valid),
    .o_entry      (w_head),
    .o_count      (w_buf_count)
  );

endmodule

// File: tb/tb_rpc2_ctrl_fifo_reader.sv
// Self-checking bench for rpc2_ctrl_fifo_reader: burst-level reference model,
// table-driven bursts, abort/reset sequences and a randomized stream.
module tb_rpc2_ctrl_fifo_reader;

  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          abort = 1'b0;
  logic          busy, done, fifo_rd_en, m_valid, m_last;
  logic          fifo_rd_ready = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [1:0]    dbg_state;

  rpc2_ctrl_fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .fifo_rd_ready(fifo_rd_ready),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard and burst-level model
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            done_cyc = -1;
  int            dut_pops = 0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  bit            src_rdy_en = 1'b0;
  bit            m_act = 1'b0;
  int            m_total = 0;
  int            m_pops = 0;
  int            m_hs = 0;
  bit            done_exp = 1'b0;

  typedef struct {
    int          len;
    logic [15:0] rdy_pat;
    logic [15:0] mrdy_pat;
    logic [15:0] base;
    int          exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pat(input logic [15:0] p, input int c);
    return (c < 16) ? p[c] : 1'b1;
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_total = 0; m_pops = 0; m_hs = 0; done_exp = 1'b0;
    exp_q.delete();
  endtask

  task automatic refresh_src();
    fifo_rd_ready = src_rdy_en && (src_q.size() != 0);
    fifo_rd_data  = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // by the effect of the coming rising edge.
  task automatic check_and_step();
    int cnt;
    bit exp_pop, exp_hs;
    cnt     = m_pops - m_hs;
    exp_pop = m_act && fifo_rd_ready && (m_pops < m_total) && (cnt < 2) && !abort;
    exp_hs  = (cnt != 0) && m_ready;
    chk("busy", busy, m_act);
    chk("fifo_rd_en", fifo_rd_en, exp_pop);
    chk("m_valid", m_valid, cnt != 0);
    chk("done", done, done_exp);
    if (cnt != 0 && exp_q.size() != 0) begin
      chk("m_data", m_data, exp_q[0]);
      chk("m_last", m_last, m_hs == m_total - 1);
    end
    if (fifo_rd_en) dut_pops++;
    if (done) done_cyc = cyc;
    done_exp = 1'b0;
    if (m_act && abort) begin
      model_reset();
    end else if (m_act) begin
      if (exp_hs) begin
        void'(exp_q.pop_front());
        m_hs++;
      end
      if (exp_pop) begin
        exp_q.push_back(src_q.pop_front());
        m_pops++;
      end
      if (exp_hs && m_hs == m_total) begin
        m_act    = 1'b0;
        done_exp = 1'b1;
      end
    end else if (start) begin
      model_reset();
      m_act   = 1'b1;
      m_total = int'(len) + 1;
    end
  endtask

  // driver: inputs are set at posedge+1, checked at the negedge
  task automatic tick();
    refresh_src();
    @(negedge clk);
    check_and_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_vec(input vec_t v);
    src_q.delete();
    for (int i = 0; i <= v.len; i++) src_q.push_back(v.base + 16'(i));
    cyc = 0; done_cyc = -1; dut_pops = 0;
    while (cyc <= v.exp_done + 2) begin
      start      = (cyc == 0);
      len        = LW'(v.len);
      src_rdy_en = pat(v.rdy_pat, cyc);
      m_ready    = pat(v.mrdy_pat, cyc);
      tick();
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, v.exp_done);
    chk("pop_count", dut_pops, v.len + 1);
    chk("src_drained", src_q.size(), 0);
    chk("idle_after", busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{len: 0,   rdy_pat: 16'hFFFF, mrdy_pat: 16'hFFFF, base: 16'h1234, exp_done: 3};
    vecs[1] = '{len: 3,   rdy_pat: 16'hFFFF, mrdy_pat: 16'hFFFF, base: 16'h00A0, exp_done: 6};
    vecs[2] = '{len: 4,   rdy_pat: 16'hFFFF, mrdy_pat: 16'hFF81, base: 16'h5000, exp_done: 12};
    vecs[3] = '{len: 2,   rdy_pat: 16'hFFD3, mrdy_pat: 16'hFFFF, base: 16'h7700, exp_done: 8};
    vecs[4] = '{len: 1,   rdy_pat: 16'hFFFF, mrdy_pat: 16'hAAAA, base: 16'h3C00, exp_done: 6};
    vecs[5] = '{len: 255, rdy_pat: 16'hFFFF, mrdy_pat: 16'hFFFF, base: 16'h8000, exp_done: 258};

    // reset state, with the FIFO claiming data to show no pop leaks out
    fifo_rd_ready = 1'b1;
    start = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, 16'h0);
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // table-driven bursts
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // abort with two words buffered after three pops
    src_q.delete();
    for (int i = 0; i < 8; i++) src_q.push_back(16'hB0 + 16'(i));
    src_rdy_en = 1'b1; dut_pops = 0;
    for (int c = 0; c < 5; c++) begin
      start   = (c == 0);
      len     = 8'd7;
      m_ready = (c == 3);
      tick();
    end
    chk("abort_pops_before", dut_pops, 3);
    chk("abort_buf_full", m_valid, 1'b1);
    abort = 1'b1; m_ready = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_m_valid", m_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_pops_total", dut_pops, 3);
    start = 1'b1; len = 8'd1; m_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    for (int c = 0; c < 20 && (m_act || done_exp); c++) tick();
    chk("restart_finished", m_act, 1'b0);
    tick();
    src_q.delete();

    // reset asserted asynchronously while in FLUSH with a full buffer
    for (int i = 0; i < 2; i++) src_q.push_back(16'hC0 + 16'(i));
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      start = (c == 0);
      len   = 8'd1;
      tick();
    end
    start = 1'b0;
    chk("pre_reset_flush", dbg_state, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_m_last", m_last, 1'b0);
    chk("arst_m_data", m_data, 16'h0);
    chk("arst_done", done, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rd_en", fifo_rd_en, 1'b0);
    model_reset();
    src_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", dbg_state, 2'd0);
    m_ready = 1'b1;
    tick();
    run_vec(vecs[5]);

    // randomized stream against the model
    model_reset();
    src_q.delete();
    for (int c = 0; c < 3000; c++) begin
      while (src_q.size() < 4) src_q.push_back(16'($urandom));
      src_rdy_en = ($urandom_range(0, 3) != 0);
      m_ready    = ($urandom_range(0, 3) != 0);
      start      = ($urandom_range(0, 5) == 0);
      len        = ($urandom_range(0, 7) == 0) ? LW'($urandom) : LW'($urandom_range(0, 6));
      abort      = ($urandom_range(0, 60) == 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; m_ready = 1'b1; src_rdy_en = 1'b1;
    for (int c = 0; c < 600 && (m_act || done_exp); c++) begin
      while (src_q.size() < 4) src_q.push_back(16'($urandom));
      tick();
    end
    chk("random_drain", m_act || done_exp, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
